mem_link_responder: RTL and testbench
=====================================

// Module: mem_link_responder
// PURPOSE
//  Memory-side endpoint of the cache<->memory serial link. Takes complete requests
//  strobed by the memory-side receiver, queues them, and performs data_mem accesses.
//  Read results are returned by driving the memory->cache sender (send/done handshake).
//  Writes get no response. Sits between recCM/sdMC and data_mem; replaces data_mem's ad-hoc sequencing.
// PARAMETERS
//  ADDR_W   10  request/memory address width
//  DATA_W   32  data word width
//  DEPTH    4   request queue entries (power of 2, >=2)
//  MEM_LAT  1   data_mem read latency in cycles (>=1)
// PORTS
//  clock        in   1       single clock, all logic on posedge
//  reset        in   1       asynchronous, active-low; all state cleared while low
//  req_read     in   1       1-cycle strobe from receiver: read request complete
//  req_write    in   1       1-cycle strobe from receiver: write request complete
//  req_addr     in   ADDR_W  request address, valid with strobe
//  req_data     in   DATA_W  write data, valid with req_write
//  mem_read     out  1       data_mem read enable
//  mem_write    out  1       data_mem write enable
//  mem_addr     out  ADDR_W  data_mem address
//  mem_wdata    out  DATA_W  data_mem write data
//  mem_rdata    in   DATA_W  data_mem read data, valid MEM_LAT cycles after mem_read rises
//  send         out  1       1-cycle start pulse to sender
//  tx_data      out  DATA_W  response data to sender
//  tx_addr      out  ADDR_W  response address to sender
//  tx_write     out  1       sender write flag; always 0 (responses are read data)
//  done_sender  in   1       sender finished transfer (1-cycle pulse)
//  busy         out  1       FSM not IDLE or queue non-empty
//  overflow     out  1       sticky: request dropped (queue full)
//  proto_err    out  1       sticky: req_read and req_write in the same cycle
// BEHAVIOUR
//  Reset: all outputs 0; queue empty; FSM IDLE; sticky flags cleared. Mid-transfer reset
//   abandons the access/response. send is not reissued after reset release.
//  Enqueue: strobe enqueues {op,addr,data} at posedge. Both strobes together: enqueue the
//   write only and set proto_err. Full and no pop that cycle: drop, set overflow.
//   Full with same-cycle pop: accepted.
//  FSM states: IDLE, MEM_WR, MEM_RD, SEND, WAIT_DONE.
//   IDLE: queue non-empty -> pop head; write -> MEM_WR, read -> MEM_RD (cnt=0).
//   MEM_WR: mem_write=1, mem_addr/mem_wdata=entry for exactly 1 cycle -> IDLE.
//   MEM_RD: mem_read=1, mem_addr=entry held MEM_LAT cycles; on last cycle latch mem_rdata
//    into tx_data and addr into tx_addr -> SEND.
//   SEND: send=1 for exactly 1 cycle -> WAIT_DONE.
//   WAIT_DONE: tx_* held stable; done_sender -> IDLE. done_sender outside WAIT_DONE ignored.
//  mem_read/mem_write never both 1. Enables are 0 outside their states; addr/data don't-care then.
//  Latency (empty queue, MEM_LAT=L): read strobe in cycle 0 -> mem_read cycles 2..1+L ->
//   send in cycle 2+L. Write strobe in cycle 0 -> mem_write in cycle 2.
//  Ordering: strict FIFO. A write queued behind a read is applied only after that read's done_sender.
//  No timeout: WAIT_DONE holds until done_sender.
//  Queue pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
//   full = MSBs differ and low bits equal; empty = pointers equal.
// STRUCTURE
//  Shared package/header: ADDR_W/DATA_W defaults, BANDWIDTH_WRITE_DATA, op encoding
//   (OP_RD=0, OP_WR=1), FSM state localparams.
//  One sub-module: link_req_fifo (sync FIFO with push/pop/full/empty, async active-low reset).
//  FSM, latency counter and tx registers live in mem_link_responder.
// TESTING
//  1 Write 0x3A5 data 0xDEADBEEF, then read 0x3A5 (memory model L=1) ->
//    mem_write cycle 2; send with tx_addr=0x3A5, tx_data=0xDEADBEEF, tx_write=0.
//  2 Read 0x010, hold done_sender low 20 cycles -> tx_* stable, no second send;
//    done_sender -> IDLE, busy=0.
//  3 Five back-to-back reads, DEPTH=4, FSM stalled in WAIT_DONE -> 5th dropped, overflow=1;
//    4 responses sent in order.
//  4 req_read and req_write together, addr 0x001 -> one mem_write only, proto_err=1,
//    no send.
//  5 Reset low during MEM_RD and during WAIT_DONE -> outputs 0, queue empty, no send after
//    release.
//  6 MEM_LAT=3, read 0x200 -> mem_read high exactly 3 cycles; data sampled on the 3rd;
//    send in cycle 5.

Source files
------------

// File: rtl/mem_link_responder_pkg.sv
// Shared definitions for the memory-side link responder: default widths,
// request op encoding and responder FSM states.
package mem_link_responder_pkg;

  localparam int ADDR_W_DEFAULT  = 10;
  localparam int DATA_W_DEFAULT  = 32;
  localparam int DEPTH_DEFAULT   = 4;
  localparam int MEM_LAT_DEFAULT = 1;

  // Width of one queued request {op, addr, data} at the default widths.
  localparam int BANDWIDTH_WRITE_DATA = 1 + ADDR_W_DEFAULT + DATA_W_DEFAULT;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MEM_WR    = 3'd1,
    MEM_RD    = 3'd2,
    SEND      = 3'd3,
    WAIT_DONE = 3'd4
  } state_e;

  function automatic int req_entry_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/mem_link_responder_if.sv
// Link-side, data_mem-side and sender-side signals of the responder.
// slave = responder view, master = surrounding environment view.
interface mem_link_responder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req_read;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              send;
  logic [DATA_W-1:0] tx_data;
  logic [ADDR_W-1:0] tx_addr;
  logic              tx_write;
  logic              done_sender;

  logic              busy;
  logic              overflow;
  logic              proto_err;

  modport slave (
    input  req_read, req_write, req_addr, req_data, mem_rdata, done_sender,
    output mem_read, mem_write, mem_addr, mem_wdata,
    output send, tx_data, tx_addr, tx_write, busy, overflow, proto_err
  );

  modport master (
    output req_read, req_write, req_addr, req_data, mem_rdata, done_sender,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    input  send, tx_data, tx_addr, tx_write, busy, overflow, proto_err
  );
endinterface

// File: rtl/mem_link_responder_fifo.sv
// link_req_fifo: synchronous request FIFO with wrap-bit pointers.
// Head entry is presented combinationally on rdata.
module link_req_fifo #(
  parameter int W     = 43,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] storage [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = storage[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clock) begin
    if (do_push) storage[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mem_link_responder.sv
// Memory-side link endpoint: queues complete requests from the receiver,
// sequences data_mem accesses and hands read results to the sender.
module mem_link_responder
  import mem_link_responder_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input logic                  clock,
  input logic                  reset,
  mem_link_responder_if.slave  bus
);
  localparam int EW    = req_entry_w(ADDR_W, DATA_W);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  op_e               req_op;
  logic              push_req;
  logic              pop;
  logic              full;
  logic              empty;
  logic [EW-1:0]     push_entry;
  logic [EW-1:0]     head;
  logic              head_op_bit;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  state_e            state;
  state_e            state_d;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic [ADDR_W-1:0] tx_addr_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              overflow_q;
  logic              proto_err_q;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic              send_en;
  logic              rd_last;

  // A simultaneous read+write strobe keeps only the write.
  assign req_op     = bus.req_write ? OP_WR : OP_RD;
  assign push_req   = bus.req_read || bus.req_write;
  assign push_entry = {req_op, bus.req_addr, bus.req_data};
  assign {head_op_bit, head_addr, head_data} = head;

  link_req_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign rd_last = (state == MEM_RD) && (cnt == CNT_LAST);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    pop       = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    send_en   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = (op_e'(head_op_bit) == OP_WR) ? MEM_WR : MEM_RD;
        end
      end
      MEM_WR: begin
        mem_wr_en = 1'b1;
        state_d   = IDLE;
      end
      MEM_RD: begin
        mem_rd_en = 1'b1;
        if (rd_last) state_d = SEND;
      end
      SEND: begin
        send_en = 1'b1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.done_sender) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cur_addr    <= '0;
      cur_data    <= '0;
      tx_addr_q   <= '0;
      tx_data_q   <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state <= state_d;
      if (pop) begin
        cur_addr <= head_addr;
        cur_data <= head_data;
        cnt      <= '0;
      end else if (state == MEM_RD) begin
        cnt <= cnt + 1'b1;
      end
      if (rd_last) begin
        tx_data_q <= bus.mem_rdata;
        tx_addr_q <= cur_addr;
      end
      if (push_req && full && !pop)         overflow_q  <= 1'b1;
      if (bus.req_read && bus.req_write)    proto_err_q <= 1'b1;
    end
  end

  assign bus.mem_read  = mem_rd_en;
  assign bus.mem_write = mem_wr_en;
  assign bus.mem_addr  = cur_addr;
  assign bus.mem_wdata = cur_data;
  assign bus.send      = send_en;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_addr   = tx_addr_q;
  assign bus.tx_write  = 1'b0;
  assign bus.busy      = (state != IDLE) || !empty;
  assign bus.overflow  = overflow_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_link_responder.sv
// Bench for mem_link_responder: vector table, hand-written corner sequences
// and a randomized run checked against a request-order reference model.
module tb_mem_link_responder;
  import mem_link_responder_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_link_responder_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();
  mem_link_responder_if #(.ADDR_W(AW), .DATA_W(DW)) if3 ();

  mem_link_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .MEM_LAT(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (if1.slave)
  );

  mem_link_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .MEM_LAT(3)) dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (if3.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // data_mem models: read data is only valid on the L-th cycle of a read run.
  logic [DW-1:0] mem1 [1024];
  logic [DW-1:0] mem3 [1024];
  int rd_run1;
  int rd_run3;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = 32'hC0DE_0000 | i;
      mem3[i] = 32'hC0DE_0000 | i;
    end
    rd_run1 = 0;
    rd_run3 = 0;
    forever begin
      @(posedge clock);
      if (if1.mem_write) mem1[if1.mem_addr] <= if1.mem_wdata;
      if (if3.mem_write) mem3[if3.mem_addr] <= if3.mem_wdata;
      rd_run1 <= if1.mem_read ? rd_run1 + 1 : 0;
      rd_run3 <= if3.mem_read ? rd_run3 + 1 : 0;
    end
  end

  always_comb if1.mem_rdata = (if1.mem_read && rd_run1 == 0) ? mem1[if1.mem_addr] : 32'hBAD0_0001;
  always_comb if3.mem_rdata = (if3.mem_read && rd_run3 == 2) ? mem3[if3.mem_addr] : 32'hBAD0_0003;

  // Event counters for dut1, sampled just after each active edge.
  int n_send1 = 0;
  int n_wr1   = 0;
  int n_rd1   = 0;
  int n_both  = 0;
  always @(posedge clock) begin
    #1;
    if (if1.send)      n_send1++;
    if (if1.mem_write) n_wr1++;
    if (if1.mem_read)  n_rd1++;
    if ((if1.mem_read && if1.mem_write) || (if3.mem_read && if3.mem_write)) n_both++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic strobe1(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if1.req_read  = rd;
    if1.req_write = wr;
    if1.req_addr  = a;
    if1.req_data  = d;
    @(negedge clock);
    if1.req_read  = 1'b0;
    if1.req_write = 1'b0;
  endtask

  task automatic wait_send(input string name, input int budget);
    int k;
    k = 0;
    while (!if1.send && k < budget) begin
      @(negedge clock);
      k++;
    end
    check({name, " send seen"}, 64'(if1.send), 64'd1);
  endtask

  task automatic serve(input logic [AW-1:0] a, input logic [DW-1:0] d, input string name);
    wait_send(name, 12);
    check({name, " tx_addr"}, 64'(if1.tx_addr), 64'(a));
    check({name, " tx_data"}, 64'(if1.tx_data), 64'(d));
    @(negedge clock);
    if1.done_sender = 1'b1;
    @(negedge clock);
    if1.done_sender = 1'b0;
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } xfer_t;

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    strobe1(!v.wr, v.wr, v.addr, v.wdata);
    check({nm, " busy c1"}, 64'(if1.busy), 64'd1);
    @(negedge clock);
    if (v.wr) begin
      check({nm, " wr c2"}, 64'({if1.mem_write, if1.mem_read}), 64'b10);
      check({nm, " wr addr/data"}, 64'({if1.mem_addr, if1.mem_wdata}), 64'({v.addr, v.wdata}));
      @(negedge clock);
      check({nm, " idle after wr"}, 64'({if1.busy, if1.send}), 64'b00);
    end else begin
      check({nm, " rd c2"}, 64'({if1.mem_read, if1.mem_write}), 64'b10);
      check({nm, " rd addr"}, 64'(if1.mem_addr), 64'(v.addr));
      @(negedge clock);
      check({nm, " send c3"}, 64'({if1.send, if1.tx_write}), 64'b10);
      check({nm, " tx addr/data"}, 64'({if1.tx_addr, if1.tx_data}), 64'({v.addr, v.exp_rdata}));
      @(negedge clock);
      check({nm, " single send"}, 64'(if1.send), 64'd0);
      if1.done_sender = 1'b1;
      @(negedge clock);
      if1.done_sender = 1'b0;
      check({nm, " idle after done"}, 64'(if1.busy), 64'd0);
    end
  endtask

  initial begin
    vec_t          vecs [9];
    logic [DW-1:0] ref_mem [1024];
    xfer_t         exp_rd [$];
    xfer_t         exp_wr [$];
    xfer_t         x;
    logic [AW-1:0] ta;
    logic [DW-1:0] td;
    int            snap_send, snap_wr, snap_rd;
    int            unstable, issued, completed, done_delay, cyc;

    vecs[0] = '{1'b1, 10'h3A5, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b0, 10'h3A5, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 10'h000, 32'h1234_5678, 32'h0};
    vecs[3] = '{1'b1, 10'h3FF, 32'hA5A5_A5A5, 32'h0};
    vecs[4] = '{1'b0, 10'h3FF, 32'h0,         32'hA5A5_A5A5};
    vecs[5] = '{1'b0, 10'h000, 32'h0,         32'h1234_5678};
    vecs[6] = '{1'b0, 10'h155, 32'h0,         32'hC0DE_0155};
    vecs[7] = '{1'b1, 10'h155, 32'h0,         32'h0};
    vecs[8] = '{1'b0, 10'h155, 32'h0,         32'h0};

    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hC0DE_0000 | i;

    if1.req_read = 0; if1.req_write = 0; if1.req_addr = '0; if1.req_data = '0; if1.done_sender = 0;
    if3.req_read = 0; if3.req_write = 0; if3.req_addr = '0; if3.req_data = '0; if3.done_sender = 0;

    // Reset state
    repeat (3) @(negedge clock);
    check("reset enables", 64'({if1.mem_read, if1.mem_write, if1.send, if1.tx_write}), 64'd0);
    check("reset status", 64'({if1.busy, if1.overflow, if1.proto_err}), 64'd0);
    check("reset tx/mem regs", 64'({if1.tx_addr, if1.tx_data, if1.mem_addr}), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Long WAIT_DONE: tx stable, no reissue
    snap_send = n_send1;
    strobe1(1'b1, 1'b0, 10'h010, 32'h0);
    wait_send("hold", 10);
    ta = if1.tx_addr;
    td = if1.tx_data;
    check("hold tx", 64'({ta, td}), 64'({10'h010, 32'hC0DE_0010}));
    unstable = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (if1.tx_addr !== ta || if1.tx_data !== td || if1.send !== 1'b0) unstable++;
    end
    check("hold stable", 64'(unstable), 64'd0);
    check("hold single send", 64'(n_send1 - snap_send), 64'd1);
    check("hold busy while waiting", 64'(if1.busy), 64'd1);
    if1.done_sender = 1'b1;
    @(negedge clock);
    if1.done_sender = 1'b0;
    check("hold idle after done", 64'(if1.busy), 64'd0);

    // Overflow: FSM stalled, five more reads
    snap_send = n_send1;
    strobe1(1'b1, 1'b0, 10'h030, 32'h0);
    wait_send("ovf lead", 10);
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      if1.req_read = 1'b1;
      if1.req_addr = AW'(10'h020 + i);
      @(negedge clock);
      check($sformatf("ovf flag after %0d", i), 64'(if1.overflow), 64'(i == 4));
    end
    if1.req_read = 1'b0;
    if1.done_sender = 1'b1;
    @(negedge clock);
    if1.done_sender = 1'b0;
    for (int i = 0; i < 4; i++)
      serve(AW'(10'h020 + i), 32'hC0DE_0020 + i, $sformatf("ovf resp%0d", i));
    repeat (10) @(negedge clock);
    check("ovf send count", 64'(n_send1 - snap_send), 64'd5);
    check("ovf drained", 64'({if1.busy, if1.overflow}), 64'b01);

    // Read+write together
    snap_send = n_send1; snap_wr = n_wr1; snap_rd = n_rd1;
    strobe1(1'b1, 1'b1, 10'h001, 32'h0BAD_F00D);
    @(negedge clock);
    check("both wr data", 64'({if1.mem_write, if1.mem_addr, if1.mem_wdata}), 64'({1'b1, 10'h001, 32'h0BAD_F00D}));
    repeat (6) @(negedge clock);
    check("both counts", 64'({8'(n_wr1 - snap_wr), 8'(n_rd1 - snap_rd), 8'(n_send1 - snap_send)}), 64'h01_00_00);
    check("both proto_err", 64'({if1.proto_err, if1.busy}), 64'b10);

    // Reset during MEM_RD
    strobe1(1'b1, 1'b0, 10'h040, 32'h0);
    @(negedge clock);
    check("rstA in MEM_RD", 64'(if1.mem_read), 64'd1);
    reset = 1'b0;
    @(negedge clock);
    check("rstA outputs", 64'({if1.mem_read, if1.mem_write, if1.send, if1.busy, if1.overflow, if1.proto_err}), 64'd0);
    check("rstA tx", 64'({if1.tx_addr, if1.tx_data}), 64'd0);
    reset = 1'b1;
    snap_send = n_send1; snap_rd = n_rd1;
    repeat (8) @(negedge clock);
    check("rstA no activity", 64'({8'(n_send1 - snap_send), 8'(n_rd1 - snap_rd), 7'd0, if1.busy}), 64'd0);

    // Reset during WAIT_DONE with a queued read behind
    strobe1(1'b1, 1'b0, 10'h050, 32'h0);
    wait_send("rstB", 10);
    @(negedge clock);
    strobe1(1'b1, 1'b0, 10'h060, 32'h0);
    check("rstB busy", 64'(if1.busy), 64'd1);
    reset = 1'b0;
    @(negedge clock);
    check("rstB outputs", 64'({if1.send, if1.busy, if1.tx_addr, if1.tx_data}), 64'd0);
    reset = 1'b1;
    snap_send = n_send1; snap_rd = n_rd1;
    repeat (10) @(negedge clock);
    check("rstB no activity", 64'({8'(n_send1 - snap_send), 8'(n_rd1 - snap_rd), 7'd0, if1.busy}), 64'd0);

    // MEM_LAT = 3 on dut3
    if3.req_read = 1'b1;
    if3.req_addr = 10'h200;
    @(negedge clock);
    if3.req_read = 1'b0;
    check("lat3 c1", 64'({if3.mem_read, if3.send}), 64'b00);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clock);
      check($sformatf("lat3 c%0d", c), 64'({if3.mem_read, if3.send, if3.mem_addr}), 64'({2'b10, 10'h200}));
    end
    @(negedge clock);
    check("lat3 c5 send", 64'({if3.mem_read, if3.send}), 64'b01);
    check("lat3 tx", 64'({if3.tx_addr, if3.tx_data}), 64'({10'h200, 32'hC0DE_0200}));
    @(negedge clock);
    if3.done_sender = 1'b1;
    @(negedge clock);
    if3.done_sender = 1'b0;
    check("lat3 idle", 64'(if3.busy), 64'd0);

    // Randomized traffic against the request-order model
    issued = 0; completed = 0; done_delay = -1; cyc = 0;
    while (cyc < 600 || (issued != completed && cyc < 1200)) begin
      if1.done_sender = 1'b0;
      if (done_delay > 0) begin
        done_delay--;
        if (done_delay == 0) begin
          if1.done_sender = 1'b1;
          completed++;
          done_delay = -1;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        if1.done_sender = 1'b1;
      end
      if (if1.mem_write) begin
        if (exp_wr.size() == 0) check("rnd extra write", 64'(if1.mem_write), 64'd0);
        else begin
          x = exp_wr.pop_front();
          check("rnd write", 64'({if1.mem_addr, if1.mem_wdata}), 64'(x));
        end
        completed++;
      end
      if (if1.send) begin
        if (exp_rd.size() == 0) check("rnd extra send", 64'(if1.send), 64'd0);
        else begin
          x = exp_rd.pop_front();
          check("rnd send", 64'({if1.tx_addr, if1.tx_data}), 64'(x));
        end
        done_delay = $urandom_range(1, 4);
      end
      if1.req_read  = 1'b0;
      if1.req_write = 1'b0;
      if (cyc < 600 && (issued - completed) < DEPTH - 1 && $urandom_range(0, 2) == 0) begin
        x.a = AW'(10'h300 | $urandom_range(0, 15));
        x.d = $urandom;
        if1.req_addr = x.a;
        if1.req_data = x.d;
        if ($urandom_range(0, 1) == 1) begin
          if1.req_write = 1'b1;
          ref_mem[x.a] = x.d;
          exp_wr.push_back(x);
        end else begin
          if1.req_read = 1'b1;
          x.d = ref_mem[x.a];
          exp_rd.push_back(x);
        end
        issued++;
      end
      @(negedge clock);
      cyc++;
    end
    if1.done_sender = 1'b0;
    if1.req_read    = 1'b0;
    if1.req_write   = 1'b0;
    check("rnd all completed", 64'(issued - completed), 64'd0);
    check("rnd queues empty", 64'({16'(exp_rd.size()), 16'(exp_wr.size())}), 64'd0);
    check("rnd flags", 64'({if1.overflow, if1.proto_err}), 64'd0);
    check("never rd and wr together", 64'(n_both), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
